ram_access_ctrl: RTL and testbench

//  Master-side sequencer that sits directly upstream of single_port_sync_ram and owns its cs/we/oe/addr/data bus.

---
 rtl/ram_access_ctrl_pkg.sv | 34 +++
 rtl/ram_access_ctrl_if.sv | 35 +++
 rtl/ram_access_ctrl_bus_io.sv | 37 +++
 rtl/ram_access_ctrl.sv | 134 +++++++++++++
 tb/tb_ram_access_ctrl.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/ram_access_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : ram_ctrl_pkg
// Brief  : Shared types, default widths and RAM bus command encodings
// Rev    : 1.0  initial release
// ============================================================================
package ram_ctrl_pkg;

    localparam int DEF_ADDR_WIDTH = 12;
    localparam int DEF_DATA_WIDTH = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PLO     = 3'd1,
        ST_PLO_CAP = 3'd2,
        ST_PHI     = 3'd3,
        ST_PHI_CAP = 3'd4,
        ST_ACC     = 3'd5,
        ST_ACC_CAP = 3'd6,
        ST_RESP    = 3'd7
    } state_e;

    typedef struct packed {
        logic cs;
        logic we;
        logic oe;
    } bus_cmd_t;

    localparam bus_cmd_t CMD_IDLE  = '{cs: 1'b0, we: 1'b0, oe: 1'b0};
    localparam bus_cmd_t CMD_READ  = '{cs: 1'b1, we: 1'b0, oe: 1'b1};
    localparam bus_cmd_t CMD_WRITE = '{cs: 1'b1, we: 1'b1, oe: 1'b0};

endpackage
`default_nettype wire

// File: rtl/ram_access_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : ram_access_ctrl_if
// Brief  : Request/response handshake between a requester and the controller
// Rev    : 1.0  initial release
// ============================================================================
interface ram_access_ctrl_if
    import ram_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic                  req_indirect;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic [ADDR_WIDTH-1:0] rsp_eff_addr;

    modport master (
        output req_valid, req_we, req_indirect, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_eff_addr
    );

    modport slave (
        input  req_valid, req_we, req_indirect, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_eff_addr
    );

endinterface
`default_nettype wire

// File: rtl/ram_access_ctrl_bus_io.sv
`default_nettype none
// ============================================================================
// Module : ram_bus_io
// Brief  : Tri-state driver for the shared RAM data bus plus a capture register
// Rev    : 1.0  initial release
// ============================================================================
module ram_bus_io
    import ram_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    input  wire logic                  drive_en_i,
    input  wire logic                  load_en_i,
    input  wire logic [DATA_WIDTH-1:0] wdata_i,
    inout  wire       [DATA_WIDTH-1:0] ram_data,
    output logic      [DATA_WIDTH-1:0] bus_o,
    output logic      [DATA_WIDTH-1:0] cap_o
);

    logic [DATA_WIDTH-1:0] cap_q;

    assign ram_data = drive_en_i ? wdata_i : {DATA_WIDTH{1'bz}};
    assign bus_o    = ram_data;
    assign cap_o    = cap_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cap_q <= '0;
        end else if (load_en_i) begin
            cap_q <= ram_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ram_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module : ram_access_ctrl
// Brief  : Byte read/write sequencer for a synchronous single-port RAM with
//          optional pointer-indirect addressing
// Rev    : 1.0  initial release
// ============================================================================
module ram_access_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,  // must not exceed 2*DATA_WIDTH
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    ram_access_ctrl_if.slave           req_if,
    output logic      [ADDR_WIDTH-1:0] ram_addr,
    output logic                       ram_cs,
    output logic                       ram_we,
    output logic                       ram_oe,
    inout  wire       [DATA_WIDTH-1:0] ram_data
);

    state_e                state_q, state_d;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] eff_q;
    logic [ADDR_WIDTH-1:0] rsp_eff_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] ptr_lo_q;
    logic [DATA_WIDTH-1:0] bus_rdata;
    logic [DATA_WIDTH-1:0] rdata_cap;
    logic                  accept;
    bus_cmd_t              cmd;

    assign accept = req_if.req_valid && (state_q == ST_IDLE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (accept) state_d = req_if.req_indirect ? ST_PLO : ST_ACC;
            ST_PLO:     state_d = ST_PLO_CAP;
            ST_PLO_CAP: state_d = ST_PHI;
            ST_PHI:     state_d = ST_PHI_CAP;
            ST_PHI_CAP: state_d = ST_ACC;
            ST_ACC:     state_d = we_q ? ST_RESP : ST_ACC_CAP;
            ST_ACC_CAP: state_d = ST_RESP;
            ST_RESP:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Bus decode uses only registered state so req_* never reaches the RAM pins.
    always_comb begin
        cmd      = CMD_IDLE;
        ram_addr = '0;
        case (state_q)
            ST_PLO, ST_PLO_CAP: begin
                cmd      = CMD_READ;
                ram_addr = addr_q;
            end
            ST_PHI, ST_PHI_CAP: begin
                cmd      = CMD_READ;
                ram_addr = addr_q + 1'b1;
            end
            ST_ACC: begin
                cmd      = we_q ? CMD_WRITE : CMD_READ;
                ram_addr = eff_q;
            end
            ST_ACC_CAP: begin
                cmd      = CMD_READ;
                ram_addr = eff_q;
            end
            default: begin
                cmd      = CMD_IDLE;
                ram_addr = '0;
            end
        endcase
    end

    assign ram_cs = cmd.cs;
    assign ram_we = cmd.we;
    assign ram_oe = cmd.oe;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            eff_q     <= '0;
            ptr_lo_q  <= '0;
            rsp_eff_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                we_q    <= req_if.req_we;
                addr_q  <= req_if.req_addr;
                wdata_q <= req_if.req_wdata;
                eff_q   <= req_if.req_addr;
            end
            if (state_q == ST_PLO_CAP) begin
                ptr_lo_q <= bus_rdata;
            end
            // Pointer bits above ADDR_WIDTH are dropped.
            if (state_q == ST_PHI_CAP) begin
                eff_q <= ADDR_WIDTH'({bus_rdata, ptr_lo_q});
            end
            if (state_d == ST_RESP) begin
                rsp_eff_q <= eff_q;
            end
        end
    end

    ram_bus_io #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_bus_io (
        .clk        (clk),
        .rst_n      (rst_n),
        .drive_en_i (ram_cs && ram_we),
        .load_en_i  (state_q == ST_ACC_CAP),
        .wdata_i    (wdata_q),
        .ram_data   (ram_data),
        .bus_o      (bus_rdata),
        .cap_o      (rdata_cap)
    );

    assign req_if.req_ready    = (state_q == ST_IDLE);
    assign req_if.rsp_valid    = (state_q == ST_RESP);
    assign req_if.rsp_rdata    = rdata_cap;
    assign req_if.rsp_eff_addr = rsp_eff_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_ram_access_ctrl
// Brief  : Scoreboard bench for ram_access_ctrl with a behavioural sync RAM
// Rev    : 1.0  initial release
// ============================================================================
module tb_ram_access_ctrl;

    localparam int AW = 12;
    localparam int DW = 8;

    typedef struct {
        logic          is_rd;
        logic [DW-1:0] rdata;
        logic [AW-1:0] eff;
        int            acc_cyc;
        int            lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic [AW-1:0] ram_addr;
    logic ram_cs, ram_we, ram_oe;
    wire  [DW-1:0] ram_data;

    int n_tests = 0;
    int n_fail  = 0;
    int n_rsp   = 0;
    int n_push  = 0;
    int cyc     = 0;
    exp_t sb[$];
    logic [DW-1:0] mdl [int];
    logic [DW-1:0] last_rd;

    // behavioural single-port synchronous RAM (registered read)
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] ram_q;

    always #20 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        if (ram_cs) begin
            if (ram_we) mem[ram_addr] <= ram_data;
            else        ram_q <= mem[ram_addr];
        end
    end
    assign ram_data = (ram_cs && ram_oe && !ram_we) ? ram_q : {DW{1'bz}};

    ram_access_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    ram_access_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_if   (bus),
        .ram_addr (ram_addr),
        .ram_cs   (ram_cs),
        .ram_we   (ram_we),
        .ram_oe   (ram_oe),
        .ram_data (ram_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [AW-1:0] eff_of(input logic ind, input logic [AW-1:0] a);
        logic [AW-1:0]   a1;
        logic [2*DW-1:0] p;
        if (!ind) return a;
        a1 = a + 12'd1;
        p  = {mdl[int'(a1)], mdl[int'(a)]};
        return p[AW-1:0];
    endfunction

    task automatic do_req(input logic we, input logic ind, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd, input bit keep, input bit track);
        int   guard = 0;
        exp_t e;
        @(negedge clk);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_indirect = ind;
        bus.req_addr     = a;
        bus.req_wdata    = wd;
        while (!bus.req_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("req_ready_wait", {31'b0, bus.req_ready}, 32'd1);
        if (track) begin
            e.is_rd   = !we;
            e.eff     = eff_of(ind, a);
            e.rdata   = we ? 8'h00 : mdl[int'(e.eff)];
            e.acc_cyc = cyc;
            e.lat     = we ? (ind ? 6 : 2) : (ind ? 7 : 3);
            if (we) mdl[int'(e.eff)] = wd;
            sb.push_back(e);
            n_push++;
        end
        @(posedge clk);
        #1;
        if (!keep) bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while (sb.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        chk("sb_drain", sb.size(), 0);
    endtask

    // Response monitor: pops the scoreboard on every rsp_valid pulse.
    always @(negedge clk) begin
        exp_t e;
        chk("oe_we_excl", {31'b0, ram_oe & ram_we}, 32'd0);
        if (bus.rsp_valid) begin
            n_rsp++;
            if (sb.size() == 0) begin
                chk("rsp_unexpected", {31'b0, bus.rsp_valid}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("rsp_latency", cyc - e.acc_cyc, e.lat);
                chk("rsp_eff_addr", bus.rsp_eff_addr, e.eff);
                if (e.is_rd) begin
                    chk("rsp_rdata", bus.rsp_rdata, e.rdata);
                    last_rd = e.rdata;
                end else begin
                    chk("rsp_rdata_hold", bus.rsp_rdata, last_rd);
                end
            end
        end
    end

    initial begin
        #(40 * 5000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        rst_n            = 1'b0;
        last_rd          = '0;
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_indirect = 1'b0;
        bus.req_addr     = '0;
        bus.req_wdata    = '0;

        // 1. reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", {31'b0, bus.req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        chk("rst_cs_we_oe", {29'b0, ram_cs, ram_we, ram_oe}, 32'd0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 0);
        chk("rst_rsp_eff", bus.rsp_eff_addr, 0);
        rst_n = 1'b1;

        // 2. direct write then direct read
        do_req(1'b1, 1'b0, 12'h005, 8'hA5, 1'b0, 1'b1);
        do_req(1'b0, 1'b0, 12'h005, 8'h00, 1'b0, 1'b1);

        // 3. indirect read through pointer at 0x010
        do_req(1'b1, 1'b0, 12'h010, 8'h34, 1'b0, 1'b1);
        do_req(1'b1, 1'b0, 12'h011, 8'hF2, 1'b0, 1'b1);
        do_req(1'b1, 1'b0, 12'h234, 8'h5C, 1'b0, 1'b1);
        do_req(1'b0, 1'b1, 12'h010, 8'h00, 1'b0, 1'b1);

        // 4. pointer fetch wraps from 0xFFF to 0x000
        do_req(1'b1, 1'b0, 12'hFFF, 8'h20, 1'b0, 1'b1);
        do_req(1'b1, 1'b0, 12'h000, 8'h01, 1'b0, 1'b1);
        do_req(1'b1, 1'b1, 12'hFFF, 8'h77, 1'b0, 1'b1);
        do_req(1'b0, 1'b0, 12'h120, 8'h00, 1'b0, 1'b1);
        drain();

        // 5. valid held high across three queued requests
        n0 = n_rsp;
        do_req(1'b1, 1'b0, 12'h300, 8'h11, 1'b1, 1'b1);
        do_req(1'b0, 1'b0, 12'h300, 8'h00, 1'b1, 1'b1);
        do_req(1'b0, 1'b1, 12'h010, 8'h00, 1'b0, 1'b1);
        drain();
        chk("b2b_pulses", n_rsp - n0, 3);

        // 6. reset during PHI of an indirect read
        n0 = n_rsp;
        do_req(1'b0, 1'b1, 12'h010, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("phi_ram_addr", ram_addr, 12'h011);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n   = 1'b1;
        last_rd = '0;
        chk("midrst_ready", {31'b0, bus.req_ready}, 32'd1);
        chk("midrst_cs", {31'b0, ram_cs}, 32'd0);
        repeat (10) @(negedge clk);
        chk("midrst_no_rsp", n_rsp - n0, 0);
        do_req(1'b0, 1'b0, 12'h005, 8'h00, 1'b0, 1'b1);
        drain();
        chk("rsp_count", n_rsp, n_push);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
